// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - SDRAM port arbiter: strict priority port 0, round-robin others, locked bursts, watchdog
module sdram_arbiter #(
    parameter int NUM_PORTS = 3,
    parameter int TIMEOUT   = 1024
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [NUM_PORTS-1:0]       req_read,
    input  logic [NUM_PORTS-1:0]       req_write,
    input  logic [NUM_PORTS-1:0]       req_lock,
    input  logic [NUM_PORTS-1:0][22:0] req_addr,
    input  logic [NUM_PORTS-1:0][31:0] req_writedata,
    output logic [31:0]                req_readdata,
    output logic [NUM_PORTS-1:0]       req_finished,
    output logic                       mem_read,
    output logic                       mem_write,
    output logic [22:0]                mem_addr,
    output logic [31:0]                mem_writedata,
    input  logic [31:0]                mem_readdata,
    input  logic                       mem_finished,
    output logic [1:0]                 grant_id,
    output logic                       timeout_err
);
    localparam int WDW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, BUSY, LOCKED} state_t;

    state_t             state, state_n;
    logic [1:0]         rr_ptr;
    logic [WDW-1:0]     wd_cnt;
    logic [NUM_PORTS-1:0] req_any;
    logic               win_valid, hi_found, lo_found;
    logic [1:0]         win_id, hi_id, lo_id;
    logic               launch, finish, abort;
    logic [1:0]         launch_id;

    assign req_any      = req_read | req_write;
    assign req_readdata = mem_readdata;

    // Round-robin search: ports above rr_ptr first, then wrap back to port 1.
    always_comb begin
        hi_found = 1'b0;
        hi_id    = 2'd0;
        lo_found = 1'b0;
        lo_id    = 2'd0;
        for (int i = 1; i < NUM_PORTS; i++) begin
            if (!hi_found && i > int'(rr_ptr) && req_any[i]) begin
                hi_found = 1'b1;
                hi_id    = 2'(i);
            end
        end
        for (int i = 1; i < NUM_PORTS; i++) begin
            if (!lo_found && i <= int'(rr_ptr) && req_any[i]) begin
                lo_found = 1'b1;
                lo_id    = 2'(i);
            end
        end
        win_valid = req_any[0] | hi_found | lo_found;
        if (req_any[0])
            win_id = 2'd0;
        else if (hi_found)
            win_id = hi_id;
        else
            win_id = lo_id;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n   = state;
        launch    = 1'b0;
        launch_id = grant_id;
        finish    = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (win_valid) begin
                    launch    = 1'b1;
                    launch_id = win_id;
                    state_n   = BUSY;
                end
            end
            BUSY: begin
                if (mem_finished) begin
                    finish  = 1'b1;
                    state_n = req_lock[grant_id] ? LOCKED : IDLE;
                end else if (wd_cnt == WDW'(TIMEOUT - 1)) begin
                    abort   = 1'b1;
                    state_n = IDLE;
                end
            end
            LOCKED: begin
                if (req_any[grant_id]) begin
                    launch  = 1'b1;
                    state_n = BUSY;
                end else if (!req_lock[grant_id]) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Completion is routed only to the owner and only while a transaction is live.
    always_comb begin
        req_finished = '0;
        if (state == BUSY && mem_finished)
            req_finished[grant_id] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_addr      <= '0;
            mem_writedata <= '0;
            grant_id      <= 2'd0;
            rr_ptr        <= 2'(NUM_PORTS - 1);
            wd_cnt        <= '0;
            timeout_err   <= 1'b0;
        end else begin
            timeout_err <= abort;
            if (launch) begin
                mem_read      <= req_read[launch_id];
                mem_write     <= req_write[launch_id] & ~req_read[launch_id];
                mem_addr      <= req_addr[launch_id];
                mem_writedata <= req_writedata[launch_id];
                grant_id      <= launch_id;
                wd_cnt        <= '0;
                if (launch_id != 2'd0)
                    rr_ptr <= launch_id;
            end else if (finish || abort) begin
                mem_read  <= 1'b0;
                mem_write <= 1'b0;
            end else if (state == BUSY) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - Vector-table and sequence bench for sdram_arbiter
module tb_sdram_arbiter;
    localparam logic [22:0] A0 = 23'h000100;
    localparam logic [22:0] A1 = 23'h000010;
    localparam logic [22:0] A2 = 23'h000200;
    localparam logic [31:0] D0 = 32'hA0A0_A0A0;
    localparam logic [31:0] D1 = 32'h1111_1111;
    localparam logic [31:0] D2 = 32'h2222_2222;

    logic            i_clk, i_rst;
    logic [2:0]      req_read, req_write, req_lock;
    logic [2:0][22:0] req_addr;
    logic [2:0][31:0] req_writedata;
    logic [31:0]     req_readdata;
    logic [2:0]      req_finished;
    logic            mem_read, mem_write;
    logic [22:0]     mem_addr;
    logic [31:0]     mem_writedata, mem_readdata;
    logic            mem_finished;
    logic [1:0]      grant_id;
    logic            timeout_err;

    int n_cmp = 0;
    int n_err = 0;

    sdram_arbiter #(.NUM_PORTS(3), .TIMEOUT(16)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .req_read(req_read), .req_write(req_write), .req_lock(req_lock),
        .req_addr(req_addr), .req_writedata(req_writedata),
        .req_readdata(req_readdata), .req_finished(req_finished),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
        .mem_finished(mem_finished), .grant_id(grant_id), .timeout_err(timeout_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        rst;
        logic [2:0]  rd, wr;
        logic        mfin;
        logic [2:0]  e_fin;
        logic        e_mrd, e_mwr;
        logic [1:0]  e_gid;
        logic [22:0] e_addr;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic rst, input logic [2:0] rd, input logic [2:0] wr,
                                input logic mfin, input logic [2:0] efin, input logic emrd,
                                input logic emwr, input logic [1:0] egid,
                                input logic [22:0] eaddr, input logic [31:0] ewdata);
        vec_t v;
        v.rst = rst; v.rd = rd; v.wr = wr; v.mfin = mfin; v.e_fin = efin;
        v.e_mrd = emrd; v.e_mwr = emwr; v.e_gid = egid; v.e_addr = eaddr; v.e_wdata = ewdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst = 1'b1; req_read = '0; req_write = '0; req_lock = '0; mem_finished = 1'b0;
        step();
        i_rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        req_addr      = {A2, A1, A0};
        req_writedata = {D2, D1, D0};
        req_lock      = '0;
        mem_readdata  = 32'hDEAD_BEEF;

        // single read: port 1, finish in the 4th busy cycle, port 0 blip ignored while busy
        vq.push_back(mk(1, 3'b000, 3'b000, 0, 3'b000, 0, 0, 0, 23'h0, 32'h0));
        vq.push_back(mk(0, 3'b010, 3'b000, 0, 3'b000, 1, 0, 1, A1, D1));
        vq.push_back(mk(0, 3'b010, 3'b000, 0, 3'b000, 1, 0, 1, A1, D1));
        vq.push_back(mk(0, 3'b011, 3'b000, 0, 3'b000, 1, 0, 1, A1, D1));
        vq.push_back(mk(0, 3'b010, 3'b000, 0, 3'b000, 1, 0, 1, A1, D1));
        vq.push_back(mk(0, 3'b010, 3'b000, 1, 3'b010, 0, 0, 1, A1, D1));
        vq.push_back(mk(0, 3'b000, 3'b000, 0, 3'b000, 0, 0, 1, A1, D1));
        // contention: order 0,1,2
        vq.push_back(mk(1, 3'b000, 3'b000, 0, 3'b000, 0, 0, 0, 23'h0, 32'h0));
        vq.push_back(mk(0, 3'b111, 3'b000, 0, 3'b000, 1, 0, 0, A0, D0));
        vq.push_back(mk(0, 3'b111, 3'b000, 1, 3'b001, 0, 0, 0, A0, D0));
        vq.push_back(mk(0, 3'b110, 3'b000, 0, 3'b000, 1, 0, 1, A1, D1));
        vq.push_back(mk(0, 3'b110, 3'b000, 1, 3'b010, 0, 0, 1, A1, D1));
        vq.push_back(mk(0, 3'b100, 3'b000, 0, 3'b000, 1, 0, 2, A2, D2));
        vq.push_back(mk(0, 3'b100, 3'b000, 1, 3'b100, 0, 0, 2, A2, D2));
        vq.push_back(mk(0, 3'b000, 3'b000, 0, 3'b000, 0, 0, 2, A2, D2));
        // contention with port 0 re-requesting: order 0,1,0,2
        vq.push_back(mk(1, 3'b000, 3'b000, 0, 3'b000, 0, 0, 0, 23'h0, 32'h0));
        vq.push_back(mk(0, 3'b111, 3'b000, 0, 3'b000, 1, 0, 0, A0, D0));
        vq.push_back(mk(0, 3'b111, 3'b000, 1, 3'b001, 0, 0, 0, A0, D0));
        vq.push_back(mk(0, 3'b110, 3'b000, 0, 3'b000, 1, 0, 1, A1, D1));
        vq.push_back(mk(0, 3'b111, 3'b000, 1, 3'b010, 0, 0, 1, A1, D1));
        vq.push_back(mk(0, 3'b101, 3'b000, 0, 3'b000, 1, 0, 0, A0, D0));
        vq.push_back(mk(0, 3'b101, 3'b000, 1, 3'b001, 0, 0, 0, A0, D0));
        vq.push_back(mk(0, 3'b100, 3'b000, 0, 3'b000, 1, 0, 2, A2, D2));
        vq.push_back(mk(0, 3'b100, 3'b000, 1, 3'b100, 0, 0, 2, A2, D2));
        vq.push_back(mk(0, 3'b000, 3'b000, 0, 3'b000, 0, 0, 2, A2, D2));
        // round-robin writes 1,2,1,2 then read+write on one port is a read
        vq.push_back(mk(1, 3'b000, 3'b000, 0, 3'b000, 0, 0, 0, 23'h0, 32'h0));
        for (int r = 0; r < 2; r++) begin
            vq.push_back(mk(0, 3'b000, 3'b110, 0, 3'b000, 0, 1, 1, A1, D1));
            vq.push_back(mk(0, 3'b000, 3'b110, 1, 3'b010, 0, 0, 1, A1, D1));
            vq.push_back(mk(0, 3'b000, 3'b110, 0, 3'b000, 0, 1, 2, A2, D2));
            vq.push_back(mk(0, 3'b000, 3'b110, 1, 3'b100, 0, 0, 2, A2, D2));
        end
        vq.push_back(mk(0, 3'b010, 3'b010, 0, 3'b000, 1, 0, 1, A1, D1));
        vq.push_back(mk(0, 3'b010, 3'b010, 1, 3'b010, 0, 0, 1, A1, D1));
        vq.push_back(mk(0, 3'b000, 3'b000, 0, 3'b000, 0, 0, 1, A1, D1));

        foreach (vq[k]) begin
            i_rst = vq[k].rst; req_read = vq[k].rd; req_write = vq[k].wr;
            mem_finished = vq[k].mfin;
            #1;
            chk($sformatf("v%0d req_finished", k), 32'(req_finished), 32'(vq[k].e_fin));
            step();
            chk($sformatf("v%0d mem_read", k), 32'(mem_read), 32'(vq[k].e_mrd));
            chk($sformatf("v%0d mem_write", k), 32'(mem_write), 32'(vq[k].e_mwr));
            chk($sformatf("v%0d grant_id", k), 32'(grant_id), 32'(vq[k].e_gid));
            chk($sformatf("v%0d mem_addr", k), 32'(mem_addr), 32'(vq[k].e_addr));
            chk($sformatf("v%0d mem_writedata", k), mem_writedata, vq[k].e_wdata);
            chk($sformatf("v%0d timeout_err", k), 32'(timeout_err), 32'h0);
        end

        // locked burst: port 2 four beats at A2..A2+3 while port 0 waits
        do_reset();
        req_read = 3'b100; req_lock = 3'b100;
        step();
        chk("lk grant mem_read", 32'(mem_read), 32'h1);
        chk("lk grant grant_id", 32'(grant_id), 32'h2);
        req_read = 3'b101;
        for (int b = 0; b < 4; b++) begin
            if (b == 3) req_lock = 3'b000;
            step();
            chk($sformatf("lk b%0d mem_read", b), 32'(mem_read), 32'h1);
            chk($sformatf("lk b%0d grant_id", b), 32'(grant_id), 32'h2);
            chk($sformatf("lk b%0d mem_addr", b), 32'(mem_addr), 32'(A2 + 23'(b)));
            mem_finished = 1'b1;
            mem_readdata = 32'hC0DE_0000 + 32'(b);
            #1;
            chk($sformatf("lk b%0d req_finished", b), 32'(req_finished), 32'h4);
            chk($sformatf("lk b%0d req_readdata", b), req_readdata, 32'hC0DE_0000 + 32'(b));
            step();
            mem_finished = 1'b0;
            chk($sformatf("lk b%0d gap mem_read", b), 32'(mem_read), 32'h0);
            chk($sformatf("lk b%0d gap grant_id", b), 32'(grant_id), 32'h2);
            req_addr[2] = A2 + 23'(b + 1);
            if (b < 3) begin
                step();
                chk($sformatf("lk b%0d next mem_read", b), 32'(mem_read), 32'h1);
                chk($sformatf("lk b%0d next grant_id", b), 32'(grant_id), 32'h2);
                chk($sformatf("lk b%0d next mem_addr", b), 32'(mem_addr), 32'(A2 + 23'(b + 1)));
            end else begin
                req_read = 3'b001;
                step();
                chk("lk port0 mem_read", 32'(mem_read), 32'h1);
                chk("lk port0 grant_id", 32'(grant_id), 32'h0);
                chk("lk port0 mem_addr", 32'(mem_addr), 32'(A0));
            end
        end
        req_addr[2] = A2;
        mem_finished = 1'b1;
        step();
        mem_finished = 1'b0; req_read = '0;

        // timeout: no mem_finished, abort after 16 busy cycles, late finish ignored
        do_reset();
        req_read = 3'b010;
        step();
        chk("to grant mem_read", 32'(mem_read), 32'h1);
        for (int c = 2; c <= 16; c++) begin
            step();
            chk($sformatf("to c%0d mem_read", c), 32'(mem_read), 32'h1);
            chk($sformatf("to c%0d timeout_err", c), 32'(timeout_err), 32'h0);
            chk($sformatf("to c%0d req_finished", c), 32'(req_finished), 32'h0);
        end
        step();
        req_read = '0;
        chk("to abort mem_read", 32'(mem_read), 32'h0);
        chk("to abort timeout_err", 32'(timeout_err), 32'h1);
        chk("to abort req_finished", 32'(req_finished), 32'h0);
        mem_finished = 1'b1;
        #1;
        chk("to late req_finished", 32'(req_finished), 32'h0);
        step();
        mem_finished = 1'b0;
        chk("to after timeout_err", 32'(timeout_err), 32'h0);
        chk("to after mem_read", 32'(mem_read), 32'h0);

        // reset during busy
        do_reset();
        req_read = 3'b010;
        step();
        step();
        chk("rst busy mem_read", 32'(mem_read), 32'h1);
        i_rst = 1'b1;
        step();
        chk("rst mem_read", 32'(mem_read), 32'h0);
        chk("rst grant_id", 32'(grant_id), 32'h0);
        chk("rst mem_addr", 32'(mem_addr), 32'h0);
        i_rst = 1'b0; req_read = '0; mem_finished = 1'b1;
        #1;
        chk("rst stale req_finished", 32'(req_finished), 32'h0);
        step();
        mem_finished = 1'b0;
        chk("rst after mem_read", 32'(mem_read), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
